// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier controller: FSM encoding,
// default operand width and the counter-width helper.
package spm_pkg;

  localparam int SPM_SIZE_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } spm_state_e;

  // Counter must reach 2*size inclusive (final product capture cycle).
  function automatic int spm_cnt_width(input int size);
    return $clog2(2 * size + 1);
  endfunction

endpackage

// File: rtl/spm_ctrl_shreg.sv
// Right-shifting register with parallel load: PISO via ser_o, SIPO via ser_i.
// shifted_o is the value the register takes on a shift, so callers can grab it same-edge.
module spm_ctrl_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] shifted_o,
  output logic         ser_o
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      if (gi == W - 1) begin : g_top
        assign shifted_o[gi] = ser_i;
      end else begin : g_low
        assign shifted_o[gi] = sh_q[gi+1];
      end
    end
  endgenerate

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = load_val_i;
    end else if (shift_i) begin
      sh_d = shifted_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q_o   = sh_q;
  assign ser_o = sh_q[0];

endmodule

// File: rtl/spm_ctrl.sv
// Controller for an external registered serial-parallel multiplier: feeds the
// multiplier bits LSB first, collects 2*SIZE product bits and presents the product.
module spm_ctrl
  import spm_pkg::*;
#(
  parameter int SIZE = SPM_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   mc,
  input  logic [SIZE-1:0]   mp,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] prod,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  output logic              spm_clr,
  input  logic              spm_p
);

  localparam int CW = spm_cnt_width(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SIZE);
  localparam logic [CW-1:0] CNT_YEND = CW'(SIZE);

  spm_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SIZE-1:0]   x_q, x_d;
  logic [2*SIZE-1:0] prod_q, prod_d;

  logic              accept;
  logic              mp_shift;
  logic              pr_shift;
  logic              mp_ser;
  logic [SIZE-1:0]   mp_q;
  logic [SIZE-1:0]   mp_next;
  logic              pr_ser;
  logic [2*SIZE-1:0] pr_q;
  logic [2*SIZE-1:0] pr_next;
  logic              unused_ok;

  spm_ctrl_shreg #(.W(SIZE)) u_mp_shreg (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (accept),
    .load_val_i (mp),
    .shift_i    (mp_shift),
    .ser_i      (1'b0),
    .q_o        (mp_q),
    .shifted_o  (mp_next),
    .ser_o      (mp_ser)
  );

  // Shadow register: product bits enter at the MSB, so bit 0 lands at the LSB after 2*SIZE shifts.
  spm_ctrl_shreg #(.W(2 * SIZE)) u_pr_shreg (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (pr_shift),
    .ser_i      (spm_p),
    .q_o        (pr_q),
    .shifted_o  (pr_next),
    .ser_o      (pr_ser)
  );

  assign unused_ok = ^{mp_q, mp_next, pr_q, pr_ser};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    prod_d   = prod_q;
    accept   = 1'b0;
    mp_shift = 1'b0;
    pr_shift = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    spm_y    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q < CNT_YEND) begin
          spm_y    = mp_ser;
          mp_shift = 1'b1;
        end
        // spm_p lags spm_y by one cycle, so nothing useful arrives at cnt=0.
        if (cnt_q != '0) begin
          pr_shift = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          prod_d  = pr_next;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      x_d = mc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      prod_q  <= prod_d;
    end
  end

  // Held in clear while reset is asserted so the multiplier never leaves reset dirty.
  assign spm_clr = (state_q == ST_CLEAR) | ~rst;
  assign spm_x   = x_q;
  assign prod    = prod_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed and random bench for spm_ctrl driving a behavioural registered
// serial-parallel multiplier model.
module tb_spm_ctrl;

  localparam int SIZE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mc = 8'h00;
  logic [7:0]  mp = 8'h00;
  logic        busy;
  logic        done;
  logic [15:0] prod;
  logic [7:0]  spm_x;
  logic        spm_y;
  logic        spm_clr;
  logic        spm_p = 1'b0;

  logic [16:0] acc_m = 17'd0;
  logic [16:0] m_sum;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Multiplier model: add x when the serial bit is set, emit the LSB, shift the rest down.
  assign m_sum = acc_m + (spm_y ? {9'd0, spm_x} : 17'd0);

  always @(posedge clk) begin
    if (spm_clr) begin
      acc_m <= 17'd0;
      spm_p <= 1'b0;
    end else begin
      acc_m <= m_sum >> 1;
      spm_p <= m_sum[0];
    end
  end

  spm_ctrl #(.SIZE(SIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mc      (mc),
    .mp      (mp),
    .busy    (busy),
    .done    (done),
    .prod    (prod),
    .spm_x   (spm_x),
    .spm_y   (spm_y),
    .spm_clr (spm_clr),
    .spm_p   (spm_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Presents a start at the current negedge and returns at the negedge of the done cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit disturb,
                        output int lat, output int busy_n, output logic [15:0] p);
    logic [15:0] prod_before;
    bit          prod_moved;
    bit          x_moved;
    prod_before = prod;
    prod_moved  = 1'b0;
    x_moved     = 1'b0;
    mc     = a;
    mp     = b;
    start  = 1'b1;
    lat    = 0;
    busy_n = 0;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    chk("clear_cycle", {29'd0, busy, spm_clr, spm_y}, 32'h6);
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (prod !== prod_before) prod_moved = 1'b1;
      if (spm_x !== a) x_moved = 1'b1;
      if (disturb && lat == 5) begin
        start = 1'b1;
        mc    = ~a;
        mp    = ~b;
      end
      if (disturb && lat == 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    p = prod;
    chk("prod_hold", {31'd0, prod_moved}, 32'd0);
    chk("x_hold", {31'd0, x_moved}, 32'd0);
    $display("op mc=%02h mp=%02h prod=%04h lat=%0d busy=%0d", a, b, p, lat, busy_n);
  endtask

  task automatic post_idle();
    @(negedge clk);
    chk("done_single", {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          busy_n;
    int          extra;
    logic [15:0] p;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] exp_p;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_prod", {16'd0, prod}, 32'd0);
    chk("rst_spm_x", {24'd0, spm_x}, 32'd0);
    chk("rst_spm_y", {31'd0, spm_y}, 32'd0);
    chk("rst_spm_clr", {31'd0, spm_clr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_spm_clr", {31'd0, spm_clr}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_op(8'h0F, 8'h0F, 1'b0, lat, busy_n, p);
    chk("f_latency", lat, 32'd19);
    chk("f_busy_cycles", busy_n, 32'd18);
    chk("f_prod", {16'd0, p}, 32'h00E1);
    post_idle();
    @(negedge clk);

    run_op(8'hFF, 8'hFF, 1'b0, lat, busy_n, p);
    chk("ff_prod", {16'd0, p}, 32'hFE01);
    chk("ff_latency", lat, 32'd19);
    run_op(8'h00, 8'hFF, 1'b0, lat, busy_n, p);
    chk("b2b_prod", {16'd0, p}, 32'h0000);
    chk("b2b_latency", lat, 32'd19);
    post_idle();

    run_op(8'h5A, 8'h03, 1'b1, lat, busy_n, p);
    chk("dist_prod", {16'd0, p}, 32'h010E);
    chk("dist_latency", lat, 32'd19);
    post_idle();
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("dist_extra_done", extra, 32'd0);
    chk("dist_spm_x", {24'd0, spm_x}, 32'h5A);

    mc    = 8'h77;
    mp    = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_prod", {16'd0, prod}, 32'd0);
    chk("abort_spm_x", {24'd0, spm_x}, 32'd0);
    chk("abort_spm_y", {31'd0, spm_y}, 32'd0);
    chk("abort_spm_clr", {31'd0, spm_clr}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_release", {29'd0, busy, spm_clr, done}, 32'd0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("abort_no_done", extra, 32'd0);
    run_op(8'h02, 8'h03, 1'b0, lat, busy_n, p);
    chk("restart_prod", {16'd0, p}, 32'h0006);
    post_idle();

    for (int i = 0; i < 1000; i++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      exp_p = 16'(ra) * 16'(rb);
      run_op(ra, rb, 1'b0, lat, busy_n, p);
      chk("rand_prod", {16'd0, p}, {16'd0, exp_p});
      chk("rand_latency", lat, 32'd19);
      if ($urandom_range(1) == 1) post_idle();
    end
    post_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
